dbus_dual_arbiter: RTL and testbench
====================================

DBUS_DUAL_ARBITER -- requirements
Module: dbus_dual_arbiter

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port dreq_i[1:0]  in  dbus_req_t x2  memory-stage requests (valid, addr 32, size, strobe 4, data 32); lane 1 is the older instruction.
REQ-004 SHALL have port req_finish_o[1:0]  out  1 x2  lane's access completed; feeds the memory stage's req_finish.
REQ-005 SHALL have port rdata_o[1:0]  out  32 x2  load data captured for each lane.
REQ-006 SHALL have port stall_o  out  1  memory stage must hold.
REQ-007 SHALL have port advance_i  in  1  memory stage advances this cycle.
REQ-008 SHALL have port flush_i  in  1  exception/ERET flush of the memory stage.
REQ-009 SHALL have port dreq_o  out  dbus_req_t  single request to the data cache.
REQ-010 SHALL have port dresp_i  in  dbus_resp_t  cache response (addr_ok, data_ok, data 32).

Function
REQ-011 SHALL serialize the two lanes onto dreq_o, with at most one transaction outstanding.
REQ-012 SHALL use FSM states IDLE, WAIT_ADDR, WAIT_DATA and DRAIN.
REQ-013 In IDLE, SHALL select lane 1 if dreq_i[1].valid && !done[1], else lane 0 if dreq_i[0].valid && !done[0], else no lane.
REQ-014 In IDLE, SHALL drive dreq_o combinationally from the selected lane.
REQ-015 In IDLE, SHALL capture the selected request into a holding register.
REQ-016 IDLE -> WAIT_DATA when addr_ok=1 in the same cycle; IDLE -> WAIT_ADDR when addr_ok=0.
REQ-017 In WAIT_ADDR, SHALL drive dreq_o from the holding register with valid=1, ignoring changes on dreq_i.
REQ-018 WAIT_ADDR -> WAIT_DATA on addr_ok.
REQ-019 When addr_ok and data_ok are both 1 in the same cycle, SHALL complete the transaction and return to IDLE.
REQ-020 In WAIT_DATA, dreq_o.valid SHALL be 0.
REQ-021 On data_ok in WAIT_DATA, SHALL set done[lane] and store dresp_i.data into rdata[lane] (stores included; data is don't-care for stores).
REQ-022 On data_ok in WAIT_DATA, SHALL go to IDLE.
REQ-023 done[i] and rdata[i] SHALL hold until advance_i or flush_i, which clear both done bits.
REQ-024 req_finish_o[i] SHALL equal done[i].
REQ-025 stall_o SHALL be 1 while any lane has valid && !done, or while the FSM is not IDLE.
REQ-026 stall_o SHALL be 0 when neither lane has a request.
REQ-027 Lane 0 SHALL never issue before lane 1 completes when both are valid.
REQ-028 flush_i in WAIT_ADDR SHALL keep valid asserted until addr_ok; a request is never retracted.
REQ-029 flush_i in WAIT_ADDR or WAIT_DATA SHALL route the FSM to DRAIN.
REQ-030 In DRAIN, SHALL discard data_ok (no done update) and then return to IDLE.
REQ-031 In DRAIN, stall_o SHALL be 1.
REQ-032 advance_i asserted while the FSM is not IDLE is illegal; an assertion SHALL flag it.
REQ-033 Latency for one lane with an ideal cache (addr_ok same cycle, data_ok next cycle) SHALL be: req_finish_o high 2 cycles after dreq_i.valid.
REQ-034 Latency for two lanes under the same conditions SHALL be 4 cycles.

Reset
REQ-035 On resetn=0, SHALL immediately force state IDLE and clear done, rdata and the holding register.
REQ-036 Under reset, dreq_o.valid, req_finish_o and stall_o SHALL be 0, including when reset is asserted mid-transaction.
REQ-037 A data_ok arriving after reset release for a pre-reset transaction is ignored.

Configuration
REQ-038 The macro DBUS_ARB_RESP_FWD_EN SHALL control response forwarding.
REQ-039 With DBUS_ARB_RESP_FWD_EN defined, req_finish_o[lane] and rdata_o[lane] SHALL be forwarded combinationally in the data_ok cycle (WAIT_DATA only, not DRAIN), saving one cycle per lane.
REQ-040 With DBUS_ARB_RESP_FWD_EN undefined, req_finish_o and rdata_o SHALL come from registers only, first visible the cycle after data_ok.

Verification
REQ-041 Lane 1 load addr 0x8000_0010, addr_ok same cycle, data_ok +1 with data 0x1234_5678 -> rdata_o[1]=0x1234_5678; req_finish_o[1]=1 at cycle 2 (cycle 1 with forwarding); stall_o falls the same cycle.
REQ-042 Both lanes valid (lane 1 store 0xA000_0000 strobe 4'hF, lane 0 load 0xA000_0004) -> dreq_o shows lane 1 first, lane 0 only after lane 1's data_ok; stall_o=1 until req_finish_o=2'b11.
REQ-043 addr_ok held 0 for 3 cycles while dreq_i[1].addr changes -> dreq_o.addr stays at the originally captured value until addr_ok.
REQ-044 addr_ok and data_ok both 1 in the issue cycle -> transaction completes in 1 cycle; the next lane issues the following cycle.
REQ-045 flush_i in WAIT_DATA then data_ok -> done stays 2'b00, rdata unchanged, FSM reaches IDLE, stall_o=0 afterwards.
REQ-046 resetn pulsed low in WAIT_ADDR -> dreq_o.valid=0 immediately; all outputs 0; a stray data_ok after release is ignored.

Source files
------------

// File: rtl/dbus_dual_arbiter.sv
// Dual-lane data-bus arbiter: serializes two memory-stage requests onto one cache port.
// Define DBUS_ARB_RESP_FWD_EN to forward req_finish/rdata combinationally in the data_ok cycle.
module dbus_dual_arbiter (
   input  logic             clk,
   input  logic             resetn,
   input  logic [1:0]       dreq_valid_i,
   input  logic [1:0][31:0] dreq_addr_i,
   input  logic [1:0][2:0]  dreq_size_i,
   input  logic [1:0][3:0]  dreq_strobe_i,
   input  logic [1:0][31:0] dreq_data_i,
   output logic [1:0]       req_finish_o,
   output logic [1:0][31:0] rdata_o,
   output logic             stall_o,
   input  logic             advance_i,
   input  logic             flush_i,
   output logic             dreq_valid_o,
   output logic [31:0]      dreq_addr_o,
   output logic [2:0]       dreq_size_o,
   output logic [3:0]       dreq_strobe_o,
   output logic [31:0]      dreq_data_o,
   input  logic             dresp_addr_ok_i,
   input  logic             dresp_data_ok_i,
   input  logic [31:0]      dresp_data_i
);

   typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DRAIN} state_t;

   state_t           state, state_next;
   logic [1:0]       done, done_next;
   logic [1:0][31:0] rdata, rdata_next;
   logic             killed, killed_next;
   logic             hold_lane;
   logic [31:0]      hold_addr;
   logic [2:0]       hold_size;
   logic [3:0]       hold_strobe;
   logic [31:0]      hold_data;
   logic             sel_valid, sel_lane;
   logic             cur_lane;
   logic             issue_valid;
   logic             complete;
   logic             fwd_hit;
   logic             busy;

   // Lane 1 holds the older instruction, so it always wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_lane  = 1'b0;
      if (dreq_valid_i[1] && !done[1]) begin
         sel_valid = 1'b1;
         sel_lane  = 1'b1;
      end else if (dreq_valid_i[0] && !done[0]) begin
         sel_valid = 1'b1;
      end
   end

   assign cur_lane      = (state == IDLE) ? sel_lane : hold_lane;
   assign issue_valid   = (state == IDLE) ? sel_valid : (state == WAIT_ADDR);
   assign dreq_valid_o  = resetn && issue_valid;
   assign dreq_addr_o   = (state == IDLE) ? dreq_addr_i[sel_lane]   : hold_addr;
   assign dreq_size_o   = (state == IDLE) ? dreq_size_i[sel_lane]   : hold_size;
   assign dreq_strobe_o = (state == IDLE) ? dreq_strobe_i[sel_lane] : hold_strobe;
   assign dreq_data_o   = (state == IDLE) ? dreq_data_i[sel_lane]   : hold_data;

   // killed remembers a flush seen before addr_ok so the accepted request is drained, not recorded.
   always_comb begin
      state_next  = state;
      killed_next = 1'b0;
      complete    = 1'b0;
      case (state)
         IDLE: begin
            killed_next = flush_i;
            if (sel_valid) begin
               if (dresp_addr_ok_i && dresp_data_ok_i) begin
                  complete = !flush_i;
               end else if (dresp_addr_ok_i) begin
                  state_next = flush_i ? DRAIN : WAIT_DATA;
               end else begin
                  state_next = WAIT_ADDR;
               end
            end
         end
         WAIT_ADDR: begin
            killed_next = killed || flush_i;
            if (dresp_addr_ok_i) begin
               if (dresp_data_ok_i) begin
                  complete   = !(killed || flush_i);
                  state_next = IDLE;
               end else begin
                  state_next = (killed || flush_i) ? DRAIN : WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            if (dresp_data_ok_i) begin
               complete   = !flush_i;
               state_next = IDLE;
            end else if (flush_i) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (dresp_data_ok_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A pipeline advance or flush clears the done bits and wins over a same-cycle completion.
   always_comb begin
      done_next  = (advance_i || flush_i) ? 2'b00 : done;
      rdata_next = rdata;
      if (complete) begin
         rdata_next[cur_lane] = dresp_data_i;
         if (!advance_i) done_next[cur_lane] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         done        <= '0;
         rdata       <= '0;
         killed      <= 1'b0;
         hold_lane   <= 1'b0;
         hold_addr   <= '0;
         hold_size   <= '0;
         hold_strobe <= '0;
         hold_data   <= '0;
      end else begin
         state  <= state_next;
         done   <= done_next;
         rdata  <= rdata_next;
         killed <= killed_next;
         if (state == IDLE && sel_valid) begin
            hold_lane   <= sel_lane;
            hold_addr   <= dreq_addr_i[sel_lane];
            hold_size   <= dreq_size_i[sel_lane];
            hold_strobe <= dreq_strobe_i[sel_lane];
            hold_data   <= dreq_data_i[sel_lane];
         end
      end
   end

`ifdef DBUS_ARB_RESP_FWD_EN
   // Forward only a live WAIT_DATA completion; drained or single-cycle completions come from registers.
   assign fwd_hit = (state == WAIT_DATA) && dresp_data_ok_i && !flush_i;

   always_comb begin
      req_finish_o = done;
      rdata_o      = rdata;
      if (fwd_hit) begin
         req_finish_o[hold_lane] = 1'b1;
         rdata_o[hold_lane]      = dresp_data_i;
      end
   end
`else
   assign fwd_hit      = 1'b0;
   assign req_finish_o = done;
   assign rdata_o      = rdata;
`endif

   assign busy    = (state != IDLE) && !fwd_hit;
   assign stall_o = resetn && ((|(dreq_valid_i & ~req_finish_o)) || busy);

   // The memory stage may only move on once the arbiter is idle (or finishing via forwarding).
   assert property (@(posedge clk) disable iff (!resetn) !(advance_i && busy))
      else $error("advance_i asserted while arbiter busy");

endmodule

// File: tb/tb_dbus_dual_arbiter.sv
// Self-checking bench for dbus_dual_arbiter: random lane/cache timing against a schedule model.
// Honors DBUS_ARB_RESP_FWD_EN for the forwarded completion timing.
module tb_dbus_dual_arbiter;

   logic             clk = 1'b0;
   logic             resetn;
   logic [1:0]       dreq_valid;
   logic [1:0][31:0] dreq_addr;
   logic [1:0][2:0]  dreq_size;
   logic [1:0][3:0]  dreq_strobe;
   logic [1:0][31:0] dreq_data;
   logic [1:0]       req_finish;
   logic [1:0][31:0] rdata;
   logic             stall;
   logic             advance;
   logic             flush;
   logic             dreq_valid_o;
   logic [31:0]      dreq_addr_o;
   logic [2:0]       dreq_size_o;
   logic [3:0]       dreq_strobe_o;
   logic [31:0]      dreq_data_o;
   logic             addr_ok;
   logic             data_ok;
   logic [31:0]      resp_data;

   int               checks = 0;
   int               errors = 0;
   logic [1:0][31:0] exp_rdata;

   dbus_dual_arbiter dut (
      .clk             (clk),
      .resetn          (resetn),
      .dreq_valid_i    (dreq_valid),
      .dreq_addr_i     (dreq_addr),
      .dreq_size_i     (dreq_size),
      .dreq_strobe_i   (dreq_strobe),
      .dreq_data_i     (dreq_data),
      .req_finish_o    (req_finish),
      .rdata_o         (rdata),
      .stall_o         (stall),
      .advance_i       (advance),
      .flush_i         (flush),
      .dreq_valid_o    (dreq_valid_o),
      .dreq_addr_o     (dreq_addr_o),
      .dreq_size_o     (dreq_size_o),
      .dreq_strobe_o   (dreq_strobe_o),
      .dreq_data_o     (dreq_data_o),
      .dresp_addr_ok_i (addr_ok),
      .dresp_data_ok_i (data_ok),
      .dresp_data_i    (resp_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic a_ok, input logic d_ok, input logic [31:0] d,
                                input logic adv, input logic fl);
      addr_ok   = a_ok;
      data_ok   = d_ok;
      resp_data = d;
      advance   = adv;
      flush     = fl;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"},  32'(dreq_valid_o), 32'(0));
      checkOutput({tag, "_stall"},  32'(stall), 32'(0));
      checkOutput({tag, "_finish"}, 32'(req_finish), 32'(0));
   endtask

   // Each lane's transaction is scheduled arithmetically: issue, addr_ok after a cycles, data_ok d
   // cycles later; the next lane issues the cycle after data_ok.
   task automatic runEpisode(input logic [1:0] vmask, input int a1, input int d1, input int a0,
                             input int d0, input logic [31:0] addr1, input logic [31:0] addr0,
                             input logic [31:0] resp1, input logic [31:0] resp0);
      int          ad[2], dd[2], issue_t[2], addr_t[2], data_t[2], vis_t[2];
      int          next_issue, last_vis;
      logic [31:0] ea[2], er[2], wd[2];
      logic        exp_valid, a_ok, d_ok, fin;
      logic [31:0] d_val;
      int          cur;
      ad[1] = a1; dd[1] = d1; ad[0] = a0; dd[0] = d0;
      ea[1] = addr1; ea[0] = addr0; er[1] = resp1; er[0] = resp0;
      next_issue = 0;
      last_vis   = 0;
      for (int l = 1; l >= 0; l--) begin
         wd[l] = $urandom;
         issue_t[l] = 1000; addr_t[l] = 1000; data_t[l] = 1000; vis_t[l] = 1000;
         if (vmask[l]) begin
            issue_t[l] = next_issue;
            addr_t[l]  = issue_t[l] + ad[l];
            data_t[l]  = addr_t[l] + dd[l];
            vis_t[l]   = data_t[l] + 1;
`ifdef DBUS_ARB_RESP_FWD_EN
            if (dd[l] >= 1) vis_t[l] = data_t[l];
`endif
            next_issue = data_t[l] + 1;
            last_vis   = vis_t[l];
         end
      end
      for (int c = 0; c <= last_vis; c++) begin
         dreq_valid = vmask;
         a_ok = 1'b0; d_ok = 1'b0; d_val = $urandom;
         exp_valid = 1'b0; cur = 0;
         for (int l = 0; l < 2; l++) begin
            dreq_addr[l]   = (vmask[l] && c > issue_t[l]) ? $urandom : ea[l];
            dreq_data[l]   = wd[l];
            dreq_size[l]   = 3'(l + 1);
            dreq_strobe[l] = 4'hF;
            if (c == addr_t[l]) a_ok = 1'b1;
            if (c == data_t[l]) begin d_ok = 1'b1; d_val = er[l]; end
            if (c >= issue_t[l] && c <= addr_t[l]) begin exp_valid = 1'b1; cur = l; end
         end
         applyStimulus(a_ok, d_ok, d_val, c == last_vis, 1'b0);
         @(negedge clk);
         checkOutput("dreq_valid", 32'(dreq_valid_o), 32'(exp_valid));
         if (exp_valid) begin
            checkOutput("dreq_addr", dreq_addr_o, ea[cur]);
            checkOutput("dreq_wdata", dreq_data_o, wd[cur]);
         end
         for (int l = 0; l < 2; l++) begin
            fin = vmask[l] && (c >= vis_t[l]);
            checkOutput(l == 1 ? "finish1" : "finish0", 32'(req_finish[l]), 32'(fin));
            checkOutput(l == 1 ? "rdata1" : "rdata0", rdata[l], fin ? er[l] : exp_rdata[l]);
         end
         checkOutput("stall", 32'(stall), 32'(c < last_vis));
         nextCycle();
      end
      for (int l = 0; l < 2; l++) if (vmask[l]) exp_rdata[l] = er[l];
      dreq_valid = 2'b00;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkIdle("after_advance");
      nextCycle();
   endtask

   initial begin
      resetn      = 1'b0;
      dreq_valid  = 2'b11;
      dreq_addr   = '0;
      dreq_size   = '0;
      dreq_strobe = '0;
      dreq_data   = '0;
      exp_rdata   = '0;
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      @(negedge clk);
      checkIdle("in_reset");
      checkOutput("in_reset_rdata", rdata[1], 32'h0);
      dreq_valid = 2'b00;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      nextCycle();

      // Directed: single lane ideal cache, both lanes, long addr_ok stall, single-cycle completions
      runEpisode(2'b10, 0, 1, 0, 0, 32'h8000_0010, 32'h0, 32'h1234_5678, 32'h0);
      runEpisode(2'b11, 0, 1, 0, 1, 32'hA000_0000, 32'hA000_0004, 32'h5555_AAAA, 32'hCAFE_F00D);
      runEpisode(2'b10, 3, 1, 0, 0, 32'h8000_0100, 32'h0, 32'h0BAD_F00D, 32'h0);
      runEpisode(2'b11, 0, 0, 0, 0, 32'h8000_0200, 32'h8000_0204, 32'h1111_2222, 32'h3333_4444);
      runEpisode(2'b01, 2, 0, 0, 2, 32'h0, 32'h8000_0300, 32'h0, 32'h7777_8888);
      runEpisode(2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

      for (int i = 0; i < 40; i++) begin
         runEpisode(2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom, $urandom);
      end

      // Flush while waiting for data: the late data_ok is drained and nothing is recorded
      dreq_valid = 2'b10;
      dreq_addr[1] = 32'h9000_0000;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_wd_issue", 32'(dreq_valid_o), 32'(1));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush_wd_stall", 32'(stall), 32'(1));
      nextCycle();
      dreq_valid = 2'b00;
      applyStimulus(1'b0, 1'b1, 32'hFEED_FACE, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("drain_stall", 32'(stall), 32'(1));
      checkOutput("drain_finish", 32'(req_finish), 32'(0));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkIdle("flush_wd_done");
      checkOutput("flush_wd_rdata", rdata[1], exp_rdata[1]);
      nextCycle();

      // Flush while waiting for addr_ok: the request stays on the bus until accepted, then drains
      dreq_valid = 2'b01;
      dreq_addr[0] = 32'h9000_0040;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nextCycle();
      dreq_addr[0] = 32'h1357_9BDF;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush_wa_valid", 32'(dreq_valid_o), 32'(1));
      checkOutput("flush_wa_addr", dreq_addr_o, 32'h9000_0040);
      nextCycle();
      dreq_valid = 2'b00;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_wa_hold", 32'(dreq_valid_o), 32'(1));
      checkOutput("flush_wa_stall", 32'(stall), 32'(1));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_wa_accept", 32'(dreq_valid_o), 32'(1));
      nextCycle();
      applyStimulus(1'b0, 1'b1, 32'h2468_ACE0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_wa_drain_valid", 32'(dreq_valid_o), 32'(0));
      checkOutput("flush_wa_drain_stall", 32'(stall), 32'(1));
      checkOutput("flush_wa_drain_finish", 32'(req_finish), 32'(0));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkIdle("flush_wa_done");
      checkOutput("flush_wa_rdata", rdata[0], exp_rdata[0]);
      nextCycle();

      // Reset in the middle of an address wait, then a stray data_ok after release
      dreq_valid = 2'b10;
      dreq_addr[1] = 32'h8800_0000;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nextCycle();
      @(negedge clk);
      checkOutput("pre_reset_valid", 32'(dreq_valid_o), 32'(1));
      #1 resetn = 1'b0;
      #1;
      checkIdle("mid_reset");
      checkOutput("mid_reset_rdata1", rdata[1], 32'h0);
      checkOutput("mid_reset_rdata0", rdata[0], 32'h0);
      exp_rdata = '0;
      dreq_valid = 2'b00;
      nextCycle();
      resetn = 1'b1;
      nextCycle();
      applyStimulus(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stray_finish", 32'(req_finish), 32'(0));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkIdle("post_stray");
      checkOutput("post_stray_rdata1", rdata[1], 32'h0);
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
